// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one serial memory channel between the fetch port and the
// data port. Round-robin arbitration, one transaction in flight, read requests
// packed as 5-byte messages and masked writes as 9-byte messages.
module mem_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_mask,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        tx_flag,
  output logic [4:0]  tx_length,
  output logic [71:0] tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [4:0]  rx_length,
  input  logic [71:0] rx_data,
  output logic        rx_flag,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state;
  logic   last_data;   // 1: the data port won the most recent grant
  logic   port_data;   // 1: current transaction belongs to the data port
  logic   op_write;
  logic   grant_fetch;
  logic   grant_data;
  logic   unused_rx_bits;

  // Read request message: address in the low word, bit 32 clear, rest zero.
  function automatic logic [71:0] read_msg(input logic [31:0] addr);
    read_msg = {40'h00_0000_0000, addr};
  endfunction

  // Masked write message: data, address, byte mask; top nibble zero.
  function automatic logic [71:0] write_msg(input logic [31:0] addr,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  mask);
    write_msg = {4'h0, mask, addr, wdata};
  endfunction

  // Only the low word of a reply carries data.
  assign unused_rx_bits = ^rx_data[71:32];

  assign tx_flag = (state == SEND) && tx_ready;
  assign rx_flag = rx_valid && RST;   // every offered reply is consumed at once
  assign busy    = (state != IDLE);

  // Round-robin arbiter: on a tie, grant the port that did not win last time.
  always_comb begin
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    if (if_req && mem_req) begin
      if (last_data) begin
        grant_fetch = 1'b1;
      end else begin
        grant_data = 1'b1;
      end
    end else if (if_req) begin
      grant_fetch = 1'b1;
    end else if (mem_req) begin
      grant_data = 1'b1;
    end else begin
      grant_fetch = 1'b0;
      grant_data  = 1'b0;
    end
  end

  // Transaction FSM with registered message, done pulses, read data and error flag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      last_data <= 1'b1;
      port_data <= 1'b0;
      op_write  <= 1'b0;
      tx_length <= 5'd0;
      tx_data   <= 72'h0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      if_rdata  <= 32'h0;
      mem_rdata <= 32'h0;
      err       <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      // Any reply other than a length-4 reply in WAIT is discarded as an error.
      if (rx_valid && !((state == WAIT) && (rx_length == 5'd4))) begin
        err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (grant_fetch) begin
            port_data <= 1'b0;
            last_data <= 1'b0;
            op_write  <= 1'b0;
            tx_length <= 5'd5;
            tx_data   <= read_msg(if_addr);
            state     <= SEND;
          end else if (grant_data) begin
            port_data <= 1'b1;
            last_data <= 1'b1;
            op_write  <= mem_we;
            if (mem_we && (mem_mask == 4'b0000)) begin
              // Nothing to write: complete without touching the channel.
              mem_done <= 1'b1;
              state    <= RESP;
            end else if (mem_we) begin
              tx_length <= 5'd9;
              tx_data   <= write_msg(mem_addr, mem_wdata, mem_mask);
              state     <= SEND;
            end else begin
              tx_length <= 5'd5;
              tx_data   <= read_msg(mem_addr);
              state     <= SEND;
            end
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (op_write) begin
              mem_done <= 1'b1;
              state    <= RESP;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (rx_valid && (rx_length == 5'd4)) begin
            if (port_data) begin
              mem_rdata <= rx_data[31:0];
              mem_done  <= 1'b1;
            end else begin
              if_rdata <= rx_data[31:0];
              if_done  <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected channel messages and
// completions; a monitor pops and compares them whenever the DUT presents them.
module tb_mem_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_mask = 4'h0;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        tx_flag;
  logic [4:0]  tx_length;
  logic [71:0] tx_data;
  logic        tx_ready = 1'b1;
  logic        rx_valid = 1'b0;
  logic [4:0]  rx_length = 5'd0;
  logic [71:0] rx_data = 72'h0;
  logic        rx_flag;
  logic        busy;
  logic        err;

  mem_ctrl dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .tx_flag(tx_flag), .tx_length(tx_length), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_length(rx_length), .rx_data(rx_data), .rx_flag(rx_flag),
    .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [4:0] len; logic [71:0] data; } tx_exp_t;
  typedef struct { logic port; logic [31:0] rdata; } done_exp_t;

  tx_exp_t   tx_q[$];
  done_exp_t done_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_txflag = 0;
  int n_rxflag = 0;
  logic auto_en = 1'b0;
  int t0, t, tr, f0, r0, tf, td;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_tx(input logic [4:0] len, input logic [71:0] data);
    tx_exp_t e;
    e.len = len;
    e.data = data;
    tx_q.push_back(e);
  endtask

  task automatic push_done(input logic port, input logic [31:0] rdata);
    done_exp_t e;
    e.port = port;
    e.rdata = rdata;
    done_q.push_back(e);
  endtask

  task automatic wait_tx(output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (tx_flag) begin
        at = cyc;
        return;
      end
    end
    check("tx_flag_timeout", 72'd0, 72'd1);
  endtask

  task automatic wait_done(input logic port, output int at);
    at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if ((port && mem_done) || (!port && if_done)) begin
        at = cyc;
        return;
      end
    end
    check(port ? "mem_done_timeout" : "if_done_timeout", 72'd0, 72'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_if_done"},   if_done,   72'd0);
    check({tag, "_mem_done"},  mem_done,  72'd0);
    check({tag, "_if_rdata"},  if_rdata,  72'd0);
    check({tag, "_mem_rdata"}, mem_rdata, 72'd0);
    check({tag, "_tx_flag"},   tx_flag,   72'd0);
    check({tag, "_tx_length"}, tx_length, 72'd0);
    check({tag, "_tx_data"},   tx_data,   72'd0);
    check({tag, "_rx_flag"},   rx_flag,   72'd0);
    check({tag, "_busy"},      busy,      72'd0);
    check({tag, "_err"},       err,       72'd0);
  endtask

  // Monitor: compare every sent message and every completion against the scoreboard.
  initial begin
    tx_exp_t   te;
    done_exp_t de;
    forever begin
      @(negedge CLK);
      if (rx_flag) n_rxflag++;
      if (tx_flag) begin
        n_txflag++;
        if (tx_q.size() == 0) begin
          check("tx_unexpected", 72'd0, 72'd1);
        end else begin
          te = tx_q.pop_front();
          check("tx_length", tx_length, te.len);
          check("tx_data", tx_data, te.data);
        end
      end
      if (if_done || mem_done) begin
        check("done_exclusive", if_done & mem_done, 72'd0);
        if (done_q.size() == 0) begin
          check("done_unexpected", 72'd0, 72'd1);
        end else begin
          de = done_q.pop_front();
          check("done_port", mem_done, de.port);
          check("done_rdata", de.port ? mem_rdata : if_rdata, de.rdata);
        end
      end
    end
  end

  // Auto responder: answer each read message one cycle later with {C0DE, addr[15:0]}.
  initial begin
    logic [15:0] a;
    forever begin
      @(negedge CLK);
      if (auto_en && tx_flag && (tx_length == 5'd5)) begin
        a = tx_data[15:0];
        tick();
        rx_valid = 1'b1;
        rx_length = 5'd4;
        rx_data = {40'h0, 16'hC0DE, a};
        tick();
        rx_valid = 1'b0;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #1;
    check_reset_outputs("reset");
    tick(); tick();
    RST = 1'b1;
    tick();

    // Fetch read of 0x10, reply 0xDEADBEEF
    if_req = 1'b1; if_addr = 32'h10;
    push_tx(5'd5, 72'h10);
    push_done(1'b0, 32'hDEADBEEF);
    t0 = cyc;
    wait_tx(t);
    check("rd_tx_latency", t - t0, 72'd1);
    tick();
    rx_valid = 1'b1; rx_length = 5'd4; rx_data = 72'hDEADBEEF; tr = cyc;
    @(negedge CLK);
    check("rd_rx_flag", rx_flag, 72'd1);
    check("rd_busy_wait", busy, 72'd1);
    tick();
    rx_valid = 1'b0;
    wait_done(1'b0, t);
    check("rd_done_latency", t - tr, 72'd1);
    tick();
    if_req = 1'b0;
    @(negedge CLK);
    check("rd_idle_busy", busy, 72'd0);

    // Masked store
    tick();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'h11223344; mem_mask = 4'b0011;
    push_tx(5'd9, 72'h3_0000_0100_1122_3344);
    push_done(1'b1, 32'h0);
    t0 = cyc; r0 = n_rxflag;
    wait_done(1'b1, t);
    check("wr_done_latency", t - t0, 72'd2);
    tick();
    mem_req = 1'b0; mem_we = 1'b0;
    check("wr_no_rx_flag", n_rxflag - r0, 72'd0);
    check("if_rdata_hold", if_rdata, 72'hDEADBEEF);

    // Back-pressure: tx_ready low for 10 cycles in SEND
    auto_en = 1'b1;
    tick();
    tx_ready = 1'b0; if_req = 1'b1; if_addr = 32'h80;
    push_tx(5'd5, 72'h80);
    push_done(1'b0, 32'hC0DE0080);
    f0 = n_txflag;
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("bp_busy", busy, 72'd1);
      check("bp_tx_flag", tx_flag, 72'd0);
      check("bp_tx_data", tx_data, 72'h80);
    end
    tick();
    tx_ready = 1'b1;
    wait_tx(t);
    wait_done(1'b0, t);
    tick();
    if_req = 1'b0;
    check("bp_single_tx_flag", n_txflag - f0, 72'd1);
    auto_en = 1'b0;

    // Bad-length reply in WAIT, then a good one
    tick();
    if_req = 1'b1; if_addr = 32'h20;
    push_tx(5'd5, 72'h20);
    push_done(1'b0, 32'h12345678);
    wait_tx(t);
    tick();
    rx_valid = 1'b1; rx_length = 5'd9; rx_data = 72'hFF_FFFF_FFFF_FFFF_FFFF;
    @(negedge CLK);
    check("bad_rx_flag", rx_flag, 72'd1);
    tick();
    rx_valid = 1'b0;
    @(negedge CLK);
    check("bad_err", err, 72'd1);
    check("bad_still_busy", busy, 72'd1);
    check("bad_if_rdata_kept", if_rdata, 72'hC0DE0080);
    tick(); tick();
    rx_valid = 1'b1; rx_length = 5'd4; rx_data = 72'h12345678;
    tick();
    rx_valid = 1'b0;
    wait_done(1'b0, t);
    tick();
    if_req = 1'b0;
    check("err_sticky", err, 72'd1);

    // Zero-mask write
    tick();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h300; mem_wdata = 32'hFFFFFFFF; mem_mask = 4'b0000;
    push_done(1'b1, 32'h0);
    t0 = cyc; f0 = n_txflag;
    wait_done(1'b1, t);
    check("zm_done_latency", t - t0, 72'd1);
    tick();
    mem_req = 1'b0; mem_we = 1'b0;
    check("zm_no_tx_flag", n_txflag - f0, 72'd0);

    // Reset in WAIT; a late reply in IDLE sets err
    tick();
    if_req = 1'b1; if_addr = 32'h30;
    push_tx(5'd5, 72'h30);
    wait_tx(t);
    tick();
    RST = 1'b0; if_req = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    tick(); tick();
    RST = 1'b1;
    tick();
    rx_valid = 1'b1; rx_length = 5'd4; rx_data = 72'h55;
    @(negedge CLK);
    check("late_rx_flag", rx_flag, 72'd1);
    check("late_idle", busy, 72'd0);
    tick();
    rx_valid = 1'b0;
    @(negedge CLK);
    check("late_err", err, 72'd1);
    check("late_if_rdata", if_rdata, 72'd0);

    // Tie arbitration from reset: fetch, data, fetch, data
    tick();
    RST = 1'b0;
    auto_en = 1'b1;
    if_req = 1'b1; if_addr = 32'h40;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200; mem_mask = 4'h0;
    push_tx(5'd5, 72'h40);
    push_tx(5'd5, 72'h200);
    push_done(1'b0, 32'hC0DE0040);
    push_done(1'b1, 32'hC0DE0200);
    tick();
    RST = 1'b1;
    fork
      begin
        wait_done(1'b0, tf);
        tick();
        if_req = 1'b0;
        tick();
        if_addr = 32'h44; if_req = 1'b1;
        push_tx(5'd5, 72'h44);
        push_done(1'b0, 32'hC0DE0044);
        wait_done(1'b0, tf);
        tick();
        if_req = 1'b0;
      end
      begin
        wait_done(1'b1, td);
        tick();
        mem_req = 1'b0;
        tick();
        mem_we = 1'b1; mem_addr = 32'h204; mem_wdata = 32'hCAFEF00D; mem_mask = 4'hF; mem_req = 1'b1;
        push_tx(5'd9, 72'hF_0000_0204_CAFE_F00D);
        push_done(1'b1, 32'hC0DE0200);
        wait_done(1'b1, td);
        tick();
        mem_req = 1'b0; mem_we = 1'b0;
      end
    join
    auto_en = 1'b0;
    tick(); tick();
    check("tx_q_drained", tx_q.size(), 72'd0);
    check("done_q_drained", done_q.size(), 72'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
